// File: rtl/fft_to_ram.sv
// Write side of the spectrogram ring: quantises FFT magnitudes to 4-bit pixels and stores
// the lower half of each frame into a ring of rows spread across one-hot selected RAM banks.
module fft_to_ram #(
    parameter int unsigned NO_BANKS       = 2,
    parameter int unsigned RAM_ADDR_WIDTH = 12,
    parameter int unsigned NO_FFTS        = 50,
    parameter int unsigned FFT_SIZE       = 256,
    parameter int unsigned MAG_W          = 16,
    parameter int unsigned MAG_SHIFT      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic [MAG_W-1:0]             in_mag,
    output logic                         wr_en,
    output logic [NO_BANKS-1:0]          wr_bank_select,
    output logic [RAM_ADDR_WIDTH-1:0]    wr_address,
    output logic [3:0]                   wr_data,
    output logic [$clog2(NO_FFTS)-1:0]   oldest_fft_idx,
    output logic                         frame_done,
    output logic                         frame_drop
);

    localparam int unsigned IW   = $clog2(NO_FFTS);
    localparam int unsigned CW   = $clog2(FFT_SIZE);
    localparam int unsigned BW   = $clog2(FFT_SIZE / 2);
    localparam int unsigned HALF = FFT_SIZE / 2;

    typedef enum logic [1:0] {StIdle, StStore, StSkip} state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             wr_idx_q, wr_idx_d;
    logic [CW-1:0]             bin_cnt_q, bin_cnt_d;

    logic                      wr_en_d;
    logic [NO_BANKS-1:0]       bank_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_d;
    logic [3:0]                data_d;
    logic [IW-1:0]             oldest_d;
    logic                      done_d;
    logic                      drop_d;

    logic [MAG_W-1:0]          shifted;
    logic [3:0]                pixel;
    logic [CW-1:0]             wr_bin;
    logic [IW-1:0]             wr_idx_inc;

    assign shifted    = in_mag >> MAG_SHIFT;
    assign pixel      = (shifted > MAG_W'(15)) ? 4'hF : shifted[3:0];
    assign wr_idx_inc = (wr_idx_q == IW'(NO_FFTS - 1)) ? '0 : wr_idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        bin_cnt_d = bin_cnt_q;
        wr_en_d   = 1'b0;
        wr_bin    = bin_cnt_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;

        if (in_valid) begin
            if (in_sof) begin
                // A new frame always wins, even over the commit sample; restart in the same row.
                drop_d    = (state_q != StIdle);
                wr_en_d   = 1'b1;
                wr_bin    = '0;
                bin_cnt_d = CW'(1);
                state_d   = StStore;
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end
                    StStore: begin
                        wr_en_d   = 1'b1;
                        bin_cnt_d = bin_cnt_q + 1'b1;
                        if (bin_cnt_q == CW'(HALF - 1)) begin
                            state_d = StSkip;
                        end
                    end
                    StSkip: begin
                        bin_cnt_d = bin_cnt_q + 1'b1;
                        if (bin_cnt_q == CW'(FFT_SIZE - 1)) begin
                            wr_idx_d  = wr_idx_inc;
                            bin_cnt_d = '0;
                            done_d    = 1'b1;
                            state_d   = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // The top row bit picks the bank; the remaining row bits and the bin form the address.
    assign bank_d   = wr_en_d ? (NO_BANKS'(1) << wr_idx_q[IW-1]) : '0;
    assign addr_d   = wr_en_d ? RAM_ADDR_WIDTH'({wr_idx_q[IW-2:0], wr_bin[BW-1:0]}) : '0;
    assign data_d   = wr_en_d ? pixel : 4'h0;
    assign oldest_d = (wr_idx_d == IW'(NO_FFTS - 1)) ? '0 : wr_idx_d + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            wr_idx_q       <= '0;
            bin_cnt_q      <= '0;
            wr_en          <= 1'b0;
            wr_bank_select <= '0;
            wr_address     <= '0;
            wr_data        <= 4'h0;
            oldest_fft_idx <= IW'(1 % NO_FFTS);
            frame_done     <= 1'b0;
            frame_drop     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_idx_q       <= wr_idx_d;
            bin_cnt_q      <= bin_cnt_d;
            wr_en          <= wr_en_d;
            wr_bank_select <= bank_d;
            wr_address     <= addr_d;
            wr_data        <= data_d;
            oldest_fft_idx <= oldest_d;
            frame_done     <= done_d;
            frame_drop     <= drop_d;
        end
    end

endmodule
